// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, line levels, data width.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Byte write handshake between a producer and the UART TX FIFO.
interface uart_tx_fifo_ctrl_if;
  logic                        i_TX_DV;
  logic [uart_pkg::DATA_W-1:0] i_TX_Byte;
  logic                        o_TX_Ready;

  modport master (output i_TX_DV, output i_TX_Byte, input o_TX_Ready);
  modport slave  (input i_TX_DV, input i_TX_Byte, output o_TX_Ready);
endinterface

// File: rtl/uart_byte_fifo.sv
// Small byte FIFO: synchronous write, head visible from storage registers.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_L,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           pop_data_c,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_d;
  logic              push_ok_c;
  logic              pop_ok_c;

  assign push_ok_c  = push & ~full;
  assign pop_ok_c   = pop & ~empty;
  assign pop_data_c = mem[rd_ptr_q];

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count;
    unique case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Pointers and registered status flags.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(FIFO_DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge i_Clock) begin
    if (push_ok_c) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// 8N1 UART transmitter with input byte FIFO.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_L,
  uart_tx_fifo_ctrl_if.slave          tx_if,
  output logic                        o_TX_Serial,
  output logic                        o_TX_Active,
  output logic                        o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

  localparam int unsigned CLK_CNT_W = 12;
  localparam logic [CLK_CNT_W-1:0] CLK_LAST = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 serial_d, active_d, done_d;
  logic                 pop_c;
  logic [DATA_W-1:0]    fifo_head_c;
  logic                 fifo_full;
  logic                 fifo_empty;

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .push       (tx_if.i_TX_DV),
    .push_data  (tx_if.i_TX_Byte),
    .pop        (pop_c),
    .pop_data_c (fifo_head_c),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (o_FIFO_Count)
  );

  assign tx_if.o_TX_Ready = ~fifo_full;

  // State, counters and registered line outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      o_TX_Serial <= LINE_IDLE;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      o_TX_Serial <= serial_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
    end
  end

  // Next state and next line levels; outputs describe the state being entered.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    pop_c      = 1'b0;
    serial_d   = LINE_IDLE;
    active_d   = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d  = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        if (!fifo_empty) begin
          pop_c    = 1'b1;
          shift_d  = fifo_head_c;
          state_d  = ST_START;
          serial_d = START_LVL;
          active_d = 1'b1;
        end
      end
      ST_START: begin
        serial_d = START_LVL;
        active_d = 1'b1;
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
          serial_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      ST_DATA: begin
        active_d = 1'b1;
        serial_d = shift_q[bit_idx_q];
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d  = ST_STOP;
            serial_d = LINE_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[bit_idx_d];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      ST_STOP: begin
        active_d = 1'b1;
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = ST_CLEANUP;
            active_d   = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench: writes push expected frames, line monitors decode and compare.
module tb_uart_tx_fifo_ctrl;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } frame_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  logic       tx_serial1, tx_active1, tx_done1;
  logic       tx_serial2, tx_active2, tx_done2;
  logic [2:0] cnt1, cnt2;

  logic [1:0] ser, act, dn;
  assign ser = {tx_serial2, tx_serial1};
  assign act = {tx_active2, tx_active1};
  assign dn  = {tx_done2, tx_done1};

  frame_t q0[$];
  frame_t q1[$];
  int     last_done [2];
  int     done_cnt  [2];

  uart_tx_fifo_ctrl_if tif1();
  uart_tx_fifo_ctrl_if tif2();

  uart_tx_fifo_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .i_Clock      (clk),
    .i_Rst_L      (rst_n),
    .tx_if        (tif1),
    .o_TX_Serial  (tx_serial1),
    .o_TX_Active  (tx_active1),
    .o_TX_Done    (tx_done1),
    .o_FIFO_Count (cnt1)
  );

  uart_tx_fifo_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .i_Clock      (clk),
    .i_Rst_L      (rst_n),
    .tx_if        (tif2),
    .o_TX_Serial  (tx_serial2),
    .o_TX_Active  (tx_active2),
    .o_TX_Done    (tx_done2),
    .o_FIFO_Count (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dn[0] === 1'b1) done_cnt[0]++;
    if (dn[1] === 1'b1) done_cnt[1]++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Decode one frame whose first start-bit sample is the current negedge.
  task automatic mon_frame(input int d);
    frame_t     e;
    logic [7:0] got;
    int         act_n;
    int         start_cyc;
    int         stops;
    bit         shape_ok;
    bit         have;
    stops     = (d == 0) ? 1 : 2;
    shape_ok  = 1'b1;
    start_cyc = cyc;
    got       = '0;
    act_n     = int'(act[d]);
    for (int i = 1; i < CPB; i++) begin
      @(negedge clk);
      if (!rst_n) return;
      if (ser[d] !== 1'b0) shape_ok = 1'b0;
      act_n += int'(act[d]);
    end
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < CPB; i++) begin
        @(negedge clk);
        if (!rst_n) return;
        if (i == 0) got[b] = ser[d];
        else if (ser[d] !== got[b]) shape_ok = 1'b0;
        act_n += int'(act[d]);
      end
    end
    for (int i = 0; i < stops * CPB; i++) begin
      @(negedge clk);
      if (!rst_n) return;
      if (ser[d] !== 1'b1) shape_ok = 1'b0;
      act_n += int'(act[d]);
    end
    @(negedge clk);
    if (!rst_n) return;
    have = 1'b0;
    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame dut%0d got=%02h exp=none", d + 1, got);
    end else begin
      chk($sformatf("frame_data_dut%0d", d + 1), 32'(got), 32'(e.data));
      chk($sformatf("active_len_dut%0d_%02h", d + 1, e.data), 32'(act_n), (d == 0) ? 32'd40 : 32'd44);
      chk($sformatf("cleanup_dut%0d_%02h", d + 1, e.data), {29'd0, dn[d], act[d], ser[d]}, 32'b101);
      chk($sformatf("bit_shape_dut%0d_%02h", d + 1, e.data), 32'(shape_ok), 32'd1);
      if (e.b2b)
        chk($sformatf("idle_gap_dut%0d_%02h", d + 1, e.data), 32'(start_cyc - last_done[d]), 32'd2);
    end
    last_done[d] = cyc;
  endtask

  always begin : mon_dut1
    @(negedge clk);
    if (rst_n === 1'b1 && ser[0] === 1'b0) mon_frame(0);
  end

  always begin : mon_dut2
    @(negedge clk);
    if (rst_n === 1'b1 && ser[1] === 1'b0) mon_frame(1);
  end

  // Present one byte for one edge, then check occupancy and ready.
  task automatic wr(input int d, input logic [7:0] b, input bit acc, input bit b2b,
                    input int exp_cnt, input bit exp_rdy);
    frame_t f;
    if (d == 0) begin tif1.i_TX_DV = 1'b1; tif1.i_TX_Byte = b; end
    else        begin tif2.i_TX_DV = 1'b1; tif2.i_TX_Byte = b; end
    if (acc) begin
      f.data = b;
      f.b2b  = b2b;
      if (d == 0) q0.push_back(f); else q1.push_back(f);
    end
    @(posedge clk);
    #1;
    chk($sformatf("count_after_%02h", b), (d == 0) ? 32'(cnt1) : 32'(cnt2), 32'(exp_cnt));
    chk($sformatf("ready_after_%02h", b), (d == 0) ? 32'(tif1.o_TX_Ready) : 32'(tif2.o_TX_Ready),
        32'(exp_rdy));
  endtask

  task automatic dv_off();
    tif1.i_TX_DV = 1'b0;
    tif2.i_TX_DV = 1'b0;
  endtask

  task automatic drain(input int d, input int limit);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) > 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk($sformatf("drain_dut%0d", d + 1), (d == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string nm, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ser !== 2'b11 || act !== 2'b00 || dn !== 2'b00) bad++;
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] b2b_v [4];
    int         b2b_c [4];
    int         ovf_c [6];
    bit         ovf_r [6];
    int         done_snap;

    b2b_v = '{8'h00, 8'hFF, 8'h55, 8'h81};
    b2b_c = '{1, 1, 2, 3};
    ovf_c = '{1, 1, 2, 3, 4, 4};
    ovf_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    checks = 0;
    errors = 0;
    cyc    = 0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    last_done[0] = 0;
    last_done[1] = 0;
    tif1.i_TX_DV = 1'b0; tif1.i_TX_Byte = '0;
    tif2.i_TX_DV = 1'b0; tif2.i_TX_Byte = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_serial", 32'(tx_serial1), 32'd1);
    chk("reset_active", 32'(tx_active1), 32'd0);
    chk("reset_done",   32'(tx_done1),   32'd0);
    chk("reset_ready",  32'(tif1.o_TX_Ready), 32'd1);
    chk("reset_count",  32'(cnt1), 32'd0);
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle_chk("idle_after_reset", 100);
    @(posedge clk);
    #1;

    // Single 0xA5 frame.
    wr(0, 8'hA5, 1'b1, 1'b0, 1, 1'b1);
    dv_off();
    drain(0, 200);

    // Four writes on consecutive clocks.
    for (int i = 0; i < 4; i++) wr(0, b2b_v[i], 1'b1, (i != 0), b2b_c[i], 1'b1);
    dv_off();
    drain(0, 400);

    // Six writes into a four-entry FIFO; the last is dropped.
    for (int i = 0; i < 6; i++)
      wr(0, 8'(8'h10 + i), (i < 5), (i != 0), ovf_c[i], ovf_r[i]);
    dv_off();
    drain(0, 500);

    // Two stop bits.
    wr(1, 8'h3C, 1'b1, 1'b0, 1, 1'b1);
    dv_off();
    drain(1, 200);

    // Reset during bit 3 of 0xC3 with two bytes still queued.
    wr(0, 8'hC3, 1'b1, 1'b0, 1, 1'b1);
    wr(0, 8'h11, 1'b1, 1'b1, 1, 1'b1);
    wr(0, 8'h22, 1'b1, 1'b1, 2, 1'b1);
    dv_off();
    repeat (16) @(posedge clk);
    chk("pre_reset_in_frame", 32'(tx_active1), 32'd1);
    done_snap = done_cnt[0];
    #3 rst_n = 1'b0;
    q0.delete();
    #1;
    chk("midrst_serial", 32'(tx_serial1), 32'd1);
    chk("midrst_count",  32'(cnt1), 32'd0);
    chk("midrst_ready",  32'(tif1.o_TX_Ready), 32'd1);
    chk("midrst_active", 32'(tx_active1), 32'd0);
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    idle_chk("idle_after_midrst", 60);
    chk("midrst_no_done", 32'(done_cnt[0]), 32'(done_snap));

    chk("done_total_dut1", 32'(done_cnt[0]), 32'd10);
    chk("done_total_dut2", 32'(done_cnt[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- 8N1 UART transmitter, the transmit counterpart of the team's UART receiver. Same bit timing and framing: 1 start bit, 8 data bits LSB first, no parity, 1 or 2 stop bits.
- A small input FIFO decouples the byte producer (loopback/echo logic, command responder) from line timing.
- Sits between on-chip byte sources and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868, clocks per bit = f(i_Clock)/baud; legal range 2..4095.
- FIFO_DEPTH, 4, byte entries; power of two, 2..16.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_TX_DV  in  1  write strobe; byte accepted when i_TX_DV=1 and o_TX_Ready=1.
- i_TX_Byte  in  8  byte to enqueue.
- o_TX_Ready  out  1  FIFO not full (registered).
- o_TX_Serial  out  1  serial line, idle high (registered).
- o_TX_Active  out  1  high while a frame is on the line (START through STOP).
- o_TX_Done  out  1  one-clock pulse after each frame's last stop bit.
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Behaviour:
- Reset (async assert, sync release):
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, o_FIFO_Count=0.
  - FIFO pointers cleared; FSM to IDLE.
- Reset mid-frame: line returns high immediately on assertion. The partial frame and all queued bytes are discarded.
- Write rules:
  - Write occurs on edge E when i_TX_DV=1 and o_TX_Ready=1.
  - A write while full is silently dropped. FIFO state is unchanged.
  - o_TX_Ready depends on registered state only; there is no combinational path from i_TX_DV.
  - A write and a pop on the same edge are both performed; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP, CLEANUP.
- IDLE:
  - Line high; bit counter and clock counter zero.
  - If the FIFO is non-empty: pop the head into the 8-bit shift register, drive the line low on the same edge, go to START.
- START: line low for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
- DATA:
  - Line = shift register bit[index], each held CLKS_PER_BIT clocks.
  - Index increments 0..7; after bit 7 completes, go to STOP.
- STOP: line high for STOP_BITS*CLKS_PER_BIT clocks, then go to CLEANUP.
- CLEANUP:
  - o_TX_Done=1 for exactly this clock; line stays high.
  - Next state is IDLE unconditionally.
- Latency: a write on edge E to an empty FIFO with FSM in IDLE makes the line low from edge E+1.
- Back-to-back frames: exactly 2 high clocks (CLEANUP + IDLE) between the end of stop time and the next start bit.
- o_TX_Active=1 in START, DATA and STOP; 0 in IDLE and CLEANUP.
- Width and counter rules:
  - Clock counter is 12 bits; it counts 0..CLKS_PER_BIT-1 and resets to 0 at each bit boundary.
  - For STOP_BITS=2 the counter runs through two CLKS_PER_BIT periods (stop-bit sub-index).
  - Bit index is 3 bits.
- The shift register is loaded only at pop. Later FIFO writes never corrupt the frame in flight.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (3-bit: IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4).
  - Line level constants (LINE_IDLE=1, START_LVL=0).
  - Data width constant 8.
- Sub-module uart_byte_fifo:
  - Synchronous-write, registered-read, parameterised by FIFO_DEPTH.
  - Ports: push/pop, full/empty, count.
  - Reusable later for the RX side.

Test Plan:
- Framing, CLKS_PER_BIT=4, STOP_BITS=1, write 0xA5 once:
  - Line low 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then high 4 clocks.
  - o_TX_Done pulses 1 clock; o_TX_Active high for exactly 40 clocks.
- Back-to-back, 4 writes 0x00,0xFF,0x55,0x81 on consecutive clocks:
  - o_FIFO_Count reaches 3 (first byte already popped).
  - Four frames in order, each separated by exactly 2 idle-high clocks; 4 Done pulses.
- Overflow, FIFO_DEPTH=4, FSM busy:
  - Write 6 bytes 0x10..0x15 in consecutive clocks; o_TX_Ready drops after the FIFO holds 4.
  - 0x15 is dropped; transmitted sequence is 0x10..0x14 only.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0x3C:
  - Stop high lasts 8 clocks before CLEANUP.
  - Total o_TX_Active = 44 clocks.
- Reset mid-DATA, assert i_Rst_L=0 during bit 3 of 0xC3 with 2 bytes queued:
  - Line high within the same cycle; count=0, Ready=1, no Done pulse.
  - No frame after release until a new write.
- Idle after reset, no writes for 100 clocks: line constantly high, Active=0, Done never pulses.
